// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// After each accepted byte it holds off further issues for one full frame time.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned OVERSAMPLE     = 16,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned ACCEPT_TIMEOUT = 64,
    parameter int unsigned ID_W           = $clog2(N_REQ)
) (
    input  logic                        BCLK,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            ack,
    output logic                        tx_start,
    output logic [DATA_WIDTH-1:0]       tx_din,
    input  logic                        tx_done_tk,
    output logic                        busy,
    output logic [ID_W-1:0]             grant_id,
    output logic                        err
);

    localparam int unsigned FRAME_CYCLES = OVERSAMPLE * (DATA_WIDTH + 2) + GAP_CYCLES;
    localparam int unsigned CNT_MAX      = (FRAME_CYCLES > ACCEPT_TIMEOUT) ? FRAME_CYCLES
                                                                           : ACCEPT_TIMEOUT;
    localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nx;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         rr_ptr_nx;
    logic [ID_W-1:0]         grant_id_nx;
    logic [ID_W-1:0]         next_id;
    logic [DATA_WIDTH-1:0]   tx_din_nx;
    logic [N_REQ-1:0]        ack_nx;
    logic                    err_nx;
    logic                    tx_start_nx;
    logic                    busy_nx;
    logic                    sel_found;
    logic [ID_W-1:0]         sel_id;
    logic                    accept;
    logic                    timeout;
    logic [DATA_WIDTH-1:0]   req_bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        int unsigned     pos;
        logic [ID_W-1:0] cand;
        sel_found = 1'b0;
        sel_id    = '0;
        pos       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = 32'(rr_ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            cand = ID_W'(pos);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    assign accept  = (state == S_ISSUE) && tx_done_tk;
    assign timeout = (state == S_ISSUE) && !tx_done_tk &&
                     (cnt == CNT_W'(ACCEPT_TIMEOUT - 1));
    assign next_id = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // State register
    always_ff @(posedge BCLK or posedge reset) begin
        if (reset) begin
            state <= S_ARB;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_ARB:   if (sel_found) state_nx = S_ISSUE;
            S_ISSUE: begin
                if (accept) begin
                    state_nx = S_WAIT;
                end else if (timeout) begin
                    state_nx = S_ARB;
                end
            end
            S_WAIT:  if (cnt == CNT_W'(FRAME_CYCLES - 1)) state_nx = S_ARB;
            default: state_nx = S_ARB;
        endcase
    end

    // Output and datapath next values; counter restarts on every state change
    always_comb begin
        cnt_nx      = '0;
        rr_ptr_nx   = rr_ptr;
        grant_id_nx = grant_id;
        tx_din_nx   = tx_din;
        ack_nx      = '0;
        err_nx      = timeout;
        tx_start_nx = (state_nx == S_ISSUE);
        busy_nx     = (state_nx != S_ARB);
        if ((state != S_ARB) && (state_nx == state)) begin
            cnt_nx = cnt + CNT_W'(1);
        end
        if ((state == S_ARB) && sel_found) begin
            grant_id_nx = sel_id;
            tx_din_nx   = req_bytes[sel_id];
        end
        if (accept) begin
            ack_nx = N_REQ'(1) << grant_id;
        end
        if (accept || timeout) begin
            rr_ptr_nx = next_id;
        end
    end

    // Output and datapath registers
    always_ff @(posedge BCLK or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
            tx_din   <= '0;
            ack      <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            cnt      <= cnt_nx;
            rr_ptr   <= rr_ptr_nx;
            grant_id <= grant_id_nx;
            tx_din   <= tx_din_nx;
            ack      <= ack_nx;
            err      <= err_nx;
            tx_start <= tx_start_nx;
            busy     <= busy_nx;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter among N_REQ byte producers, such as a command responder, a status reporter and a debug tap. Arbitration is round-robin. The block drives the transmitter's tx_start/tx_din pair and treats tx_done_tk as the accept strobe. It then holds off further issues for exactly one frame time, so the transmitter is never started mid-frame. It sits between the producers and the transmitter in the BCLK (oversample-tick) domain.

Parameters:
N_REQ, 4, number of requesters (2..8).
DATA_WIDTH, 8, byte width; must match the transmitter.
OVERSAMPLE, 16, BCLK ticks per bit; must match the transmitter.
GAP_CYCLES, 0, extra idle BCLK cycles inserted between frames.
ACCEPT_TIMEOUT, 64, maximum number of ISSUE cycles to wait for accept.
ID_W, $clog2(N_REQ), derived requester-index width.

Ports:
BCLK  in  1  clock, oversample tick rate.
reset  in  1  asynchronous, active-high.
req  in  N_REQ  per-requester byte-pending level.
req_data  in  N_REQ*DATA_WIDTH  packed bytes; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
ack  out  N_REQ  one-cycle pulse: this requester's byte was accepted by the transmitter.
tx_start  out  1  start request to the transmitter.
tx_din  out  DATA_WIDTH  byte to the transmitter.
tx_done_tk  in  1  transmitter accept strobe, valid while tx_start=1.
busy  out  1  high in every state except ARB.
grant_id  out  ID_W  index of the current or most recent grantee.
err  out  1  one-cycle pulse on accept timeout.

Behaviour:
- Decided: reset is asynchronous and active-high; the clock is BCLK.
- Reset values: state=ARB, tx_start=0, tx_din=0, ack=0, busy=0, grant_id=0, err=0, rr_ptr=0, all counters=0.
- Reset mid-operation aborts everything immediately. No ack or err is generated for the aborted byte.
- FRAME_CYCLES = OVERSAMPLE*(DATA_WIDTH+2) + GAP_CYCLES. With the defaults this is 160.

State ARB:
- If req is nonzero, select the first set bit searching upward from rr_ptr with wrap-around.
- On selection, latch that requester's req_data into tx_din and its index into grant_id, then go to ISSUE.
- If req is zero, stay in ARB. tx_din and grant_id hold their last values.
- ARB to ISSUE costs exactly 1 cycle after req is sampled high.

State ISSUE:
- tx_start=1 (decoded from state) and tx_din is held stable.
- If tx_done_tk=1 in a cycle, that is the accept. The next state is WAIT, with ack[grant_id]=1 registered for the first WAIT cycle only.
- tx_start is therefore high for exactly 1 cycle when the transmitter is idle.
- rr_ptr is set to grant_id+1 mod N_REQ on accept.
- The ISSUE cycle counter increments each cycle without accept. On the ACCEPT_TIMEOUT-th ISSUE cycle without accept:
  - pulse err for 1 cycle;
  - set rr_ptr to grant_id+1 mod N_REQ;
  - no ack;
  - return to ARB.
- tx_done_tk is ignored in every state except ISSUE.

State WAIT:
- The frame counter counts from 0 starting the cycle after accept.
- When it reaches FRAME_CYCLES-1, go to ARB.
- tx_start stays 0 throughout. req is ignored throughout.
- As a result, the next tx_start rises no earlier than FRAME_CYCLES+2 cycles after the accept cycle.

Handshake rules:
- A requester holds req and its req_data stable until it sees ack.
- Once ISSUE is entered, the latched byte is sent even if req drops, and ack still pulses.
- A req still high in the cycle after ack is a new byte.
- A requester with req held continuously gets back-to-back frames only when no other requester is pending.

Widths: counters are sized for max(FRAME_CYCLES, ACCEPT_TIMEOUT) and never wrap in normal use.

Test Plan:
- Single requester: req=4'b0001 with data 0xA5; model accepts on the first ISSUE cycle -> tx_start high for 1 cycle with tx_din=0xA5; ack=4'b0001 the next cycle; busy for 161 cycles; grant_id=0.
- Round-robin: all four req high with data 0x11/0x22/0x33/0x44 -> bytes issued in order 0x11, 0x22, 0x33, 0x44, 0x11; tx_start rising edges exactly 162 cycles apart; each ack pulses once per byte.
- Wrap-around: rr_ptr=3, req=4'b1001 -> requester 3 is served first, then requester 0.
- Slow accept: model asserts tx_done_tk 5 cycles into ISSUE -> tx_start high for 5 cycles, then ack, then a WAIT of 160 cycles. With tx_done_tk never asserted -> err pulses after 64 ISSUE cycles, no ack, state returns to ARB, rr_ptr advances.
- GAP_CYCLES=8 and req dropped the cycle after grant -> byte still sent and acked; next issue spacing is 170 cycles.
- Reset asserted mid-WAIT -> all outputs 0 asynchronously; after release, pending req are re-arbitrated starting from requester 0.
